// File: rtl/mem_resp_pkg.sv
// Shared types and widths for the block memory responder.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StRespond
  } state_e;

  localparam int unsigned BLOCK_W  = 512;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned OFFSET_W = 4;

endpackage

// File: rtl/mem_block_array.sv
// Block storage: synchronous write port, combinational read port, no reset.
module mem_block_array
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] wr_idx,
  input  logic [BLOCK_W-1:0]    wr_data,
  input  logic [DEPTH_LOG2-1:0] rd_idx,
  output logic [BLOCK_W-1:0]    rd_data
);

  logic [BLOCK_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/mem_block_responder.sv
// Fixed-latency 512-bit block read/write responder.
// Optional MEM_RESP_STATS_EN adds saturating read/write completion counters.
module mem_block_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mem_req_enable,
  input  logic               mem_req_rw,
  input  logic [ADDR_W-1:0]  mem_req_addr,
  input  logic [BLOCK_W-1:0] mem_req_dataout,
  output logic [BLOCK_W-1:0] mem_req_datain,
  output logic               mem_req_ready
`ifdef MEM_RESP_STATS_EN
  ,
  output logic [15:0]        stat_rd_count,
  output logic [15:0]        stat_wr_count
`endif
);

  state_e                  state_q;
  logic [7:0]              cnt_q;
  logic                    cap_rw_q;
  logic [DEPTH_LOG2-1:0]   cap_idx_q;
  logic [BLOCK_W-1:0]      cap_data_q;
  logic                    ready_q;
  logic [BLOCK_W-1:0]      datain_q;

  logic                    accept;
  logic                    commit;
  logic                    op_rw;
  logic [DEPTH_LOG2-1:0]   op_idx;
  logic [BLOCK_W-1:0]      op_data;
  logic [BLOCK_W-1:0]      rd_data;
  logic [DEPTH_LOG2-1:0]   req_idx;
  logic                    unused_addr;

  assign req_idx     = mem_req_addr[DEPTH_LOG2+OFFSET_W-1:OFFSET_W];
  assign unused_addr = ^{mem_req_addr[ADDR_W-1:DEPTH_LOG2+OFFSET_W],
                         mem_req_addr[OFFSET_W-1:0]};
  assign accept      = mem_req_enable && (state_q != StWait);

  // With LATENCY=1 the capture edge is also the edge entering RESPOND, so the
  // operation must be taken straight from the request inputs.
  always_comb begin
    commit  = 1'b0;
    op_rw   = cap_rw_q;
    op_idx  = cap_idx_q;
    op_data = cap_data_q;
    if (LATENCY == 1) begin
      commit  = accept;
      op_rw   = mem_req_rw;
      op_idx  = req_idx;
      op_data = mem_req_dataout;
    end else begin
      commit  = (state_q == StWait) && (cnt_q == 8'd1);
    end
  end

  mem_block_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk    (clk),
    .we     (commit && op_rw),
    .wr_idx (op_idx),
    .wr_data(op_data),
    .rd_idx (op_idx),
    .rd_data(rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= 8'd0;
      cap_rw_q   <= 1'b0;
      cap_idx_q  <= '0;
      cap_data_q <= '0;
      ready_q    <= 1'b0;
      datain_q   <= '0;
    end else begin
      ready_q <= commit;
      if (commit && !op_rw) begin
        datain_q <= rd_data;
      end
      case (state_q)
        StIdle, StRespond: begin
          if (accept) begin
            cap_rw_q   <= mem_req_rw;
            cap_idx_q  <= req_idx;
            cap_data_q <= mem_req_dataout;
            cnt_q      <= 8'(LATENCY - 1);
            state_q    <= (LATENCY == 1) ? StRespond : StWait;
          end else begin
            state_q    <= StIdle;
          end
        end
        StWait: begin
          cnt_q <= cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_q <= StRespond;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_req_ready  = ready_q;
  assign mem_req_datain = datain_q;

`ifdef MEM_RESP_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_rd_count <= 16'd0;
      stat_wr_count <= 16'd0;
    end else if (commit) begin
      if (op_rw && stat_wr_count != 16'hFFFF) begin
        stat_wr_count <= stat_wr_count + 16'd1;
      end
      if (!op_rw && stat_rd_count != 16'hFFFF) begin
        stat_rd_count <= stat_rd_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_block_responder.sv
// Scoreboard bench: driver pushes accepted requests, monitor checks each ready pulse.
module tb_mem_block_responder #(
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned DEPTH_LOG2 = 10
);

  logic         clk = 1'b0;
  logic         rst_n;
  logic         mem_req_enable;
  logic         mem_req_rw;
  logic [31:0]  mem_req_addr;
  logic [511:0] mem_req_dataout;
  logic [511:0] mem_req_datain;
  logic         mem_req_ready;
`ifdef MEM_RESP_STATS_EN
  logic [15:0]  stat_rd_count;
  logic [15:0]  stat_wr_count;
`endif

  always #5 clk = ~clk;

  mem_block_responder #(
    .LATENCY   (LATENCY),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_req_enable (mem_req_enable),
    .mem_req_rw     (mem_req_rw),
    .mem_req_addr   (mem_req_addr),
    .mem_req_dataout(mem_req_dataout),
    .mem_req_datain (mem_req_datain),
    .mem_req_ready  (mem_req_ready)
`ifdef MEM_RESP_STATS_EN
    ,
    .stat_rd_count  (stat_rd_count),
    .stat_wr_count  (stat_wr_count)
`endif
  );

  typedef struct {
    logic         rw;
    int unsigned  idx;
    logic [511:0] data;
    longint       due;
  } txn_t;

  txn_t         q[$];
  logic [511:0] model [int unsigned];
  longint       edge_n = 0;
  longint       free_edge = 0;
  int           checks = 0;
  int           errors = 0;
  logic [511:0] last_rd = '0;
  logic         last_known = 1'b1;
  int           rd_seen = 0;
  int           wr_seen = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string nm, input logic [511:0] got, input logic [511:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  function automatic int unsigned blk(input logic [31:0] addr);
    return (addr >> 4) % (32'd1 << DEPTH_LOG2);
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // One cycle of request inputs; the responder takes a request only once the
  // previous one has reached its response cycle.
  task automatic present(input logic en, input logic rw, input logic [31:0] addr,
                         input logic [511:0] data);
    longint e;
    txn_t   t;
    mem_req_enable  = en;
    mem_req_rw      = rw;
    mem_req_addr    = addr;
    mem_req_dataout = data;
    e = edge_n + 1;
    if (en && e >= free_edge) begin
      t.rw   = rw;
      t.idx  = blk(addr);
      t.data = data;
      t.due  = e + LATENCY - 1;
      q.push_back(t);
      free_edge = e + LATENCY;
    end
    @(negedge clk);
  endtask

  task automatic issue(input logic rw, input logic [31:0] addr, input logic [511:0] data,
                       input bit spam);
    while (edge_n + 1 < free_edge) begin
      present(spam, $urandom_range(0, 1), $urandom, rand_block());
    end
    present(1'b1, rw, addr, data);
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    mem_req_enable = 1'b0;
    q.delete();
    free_edge  = 0;
    last_rd    = '0;
    last_known = 1'b1;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: sample 1 time unit after each rising edge.
  always begin
    txn_t e;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      check("reset_ready", {511'd0, mem_req_ready}, '0);
      check("reset_datain", mem_req_datain, '0);
      rd_seen = 0;
      wr_seen = 0;
    end else if (mem_req_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got ready=1 at edge %0d expected no pending request",
                 edge_n);
      end else begin
        e = q.pop_front();
        check("ready_timing", 512'(edge_n), 512'(e.due));
        if (e.rw) begin
          if (last_known) check("hold_on_write", mem_req_datain, last_rd);
          model[e.idx] = e.data;
          wr_seen++;
        end else begin
          rd_seen++;
          if (model.exists(e.idx)) begin
            check("read_data", mem_req_datain, model[e.idx]);
            last_rd    = model[e.idx];
            last_known = 1'b1;
          end else begin
            last_known = 1'b0;
          end
        end
      end
    end else begin
      if (q.size() != 0 && q[0].due <= edge_n) begin
        checks++;
        errors++;
        $display("FAIL missing_ready: got ready=0 at edge %0d expected ready at edge %0d",
                 edge_n, q[0].due);
        void'(q.pop_front());
      end
      if (last_known) check("datain_hold", mem_req_datain, last_rd);
    end
  end

  initial begin
    rst_n           = 1'b0;
    mem_req_enable  = 1'b0;
    mem_req_rw      = 1'b0;
    mem_req_addr    = '0;
    mem_req_dataout = '0;
    @(negedge clk);
    do_reset(3);

    // Basic write then read, back-to-back write/read, WAIT-phase enable pulses.
    issue(1'b1, 32'h0000_0010, 512'hA5, 1'b0);
    issue(1'b0, 32'h0000_0010, '0, 1'b0);
    issue(1'b1, 32'h0000_0020, 512'hB1, 1'b0);
    issue(1'b0, 32'h0000_0020, '0, 1'b0);
    repeat (3) present(1'b0, 1'b0, '0, '0);
    issue(1'b1, 32'h0000_0040, 512'h77, 1'b1);
    issue(1'b0, 32'h0000_0040, '0, 1'b1);

    // Address wrap above the block index field.
    issue(1'b1, 32'h0000_4010, 512'hC3, 1'b0);
    issue(1'b0, 32'h0000_0010, '0, 1'b0);

    // Reset two cycles into a write must discard it.
    issue(1'b1, 32'h0000_0030, 512'h11, 1'b0);
    issue(1'b0, 32'h0000_0030, '0, 1'b0);
    issue(1'b1, 32'h0000_0030, 512'hDD, 1'b0);
    present(1'b0, 1'b0, '0, '0);
    do_reset(2);
    issue(1'b0, 32'h0000_0030, '0, 1'b0);

    // Random traffic over a handful of blocks with random upper/offset bits.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = ($urandom << (DEPTH_LOG2 + 4)) | ((32'd256 + $urandom_range(0, 7)) << 4)
          | ($urandom & 32'hF);
      present($urandom_range(0, 9) < 6, $urandom_range(0, 1), a, rand_block());
    end

    mem_req_enable = 1'b0;
    for (int i = 0; i < LATENCY + 10 && q.size() != 0; i++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending responses expected 0", q.size());
    end
    repeat (2) @(negedge clk);

`ifdef MEM_RESP_STATS_EN
    check("stat_rd_count", 512'(stat_rd_count), 512'((rd_seen > 65535) ? 65535 : rd_seen));
    check("stat_wr_count", 512'(stat_wr_count), 512'((wr_seen > 65535) ? 65535 : wr_seen));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
